// File: rtl/impl_window_checker.sv
// Write/retire implication checker: trigger plus REPEAT retire matches, then a write hit within [MIN_DLY:MAX_DLY].
// Define IMPL_CHK_DROP_CNT_EN to make drop_cnt count triggers ignored while an attempt is outstanding.
module impl_window_checker #(
  parameter int AW      = 5,
  parameter int RW      = 9,
  parameter int REPEAT  = 2,
  parameter int MIN_DLY = 3,
  parameter int MAX_DLY = 8,
  parameter int CNTW    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            write_en,
  input  logic            data_valid,
  input  logic [AW-1:0]   addr,
  input  logic [RW-1:0]   retire_address,
  input  logic [RW-1:0]   write_address,
  output logic            busy,
  output logic            pass,
  output logic            fail,
  output logic [CNTW-1:0] drop_cnt
);

  localparam int REPW = $clog2(REPEAT + 1);
  localparam int DLYW = $clog2(MAX_DLY + 1);

  typedef enum logic [1:0] {S_IDLE, S_ANTE, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [REPW-1:0]   rep_cnt_q, rep_cnt_d;
  logic [DLYW-1:0]   dly_cnt_q, dly_cnt_d;
  logic              busy_q, busy_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;

  logic trigger, rm, cm;

  assign trigger = write_en & data_valid;
  assign rm      = write_en && (retire_address[RW-1 -: AW] == addr);
  assign cm      = write_en && !data_valid && (write_address[RW-1 -: AW] == addr);

  // Only the top AW bits of each address bus take part in the compare.
  if (RW > AW) begin : g_low_bits
    logic unused_low;
    assign unused_low = ^{retire_address[RW-AW-1:0], write_address[RW-AW-1:0]};
  end

  // In WAIT, dly_cnt_q equals k, the offset from the antecedent end cycle.
  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    dly_cnt_d = dly_cnt_q;
    pass_d    = 1'b0;
    fail_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trigger && rm) begin
          if (REPEAT == 1) begin
            state_d   = S_WAIT;
            dly_cnt_d = DLYW'(1);
          end else begin
            state_d   = S_ANTE;
            rep_cnt_d = REPW'(1);
          end
        end
      end
      S_ANTE: begin
        if (!rm) begin
          state_d   = S_IDLE;
          rep_cnt_d = '0;
        end else if (rep_cnt_q == REPW'(REPEAT - 1)) begin
          state_d   = S_WAIT;
          rep_cnt_d = '0;
          dly_cnt_d = DLYW'(1);
        end else begin
          rep_cnt_d = rep_cnt_q + REPW'(1);
        end
      end
      S_WAIT: begin
        if (cm && (dly_cnt_q >= DLYW'(MIN_DLY))) begin
          pass_d    = 1'b1;
          state_d   = S_IDLE;
          dly_cnt_d = '0;
        end else if (dly_cnt_q == DLYW'(MAX_DLY)) begin
          fail_d    = 1'b1;
          state_d   = S_IDLE;
          dly_cnt_d = '0;
        end else begin
          dly_cnt_d = dly_cnt_q + DLYW'(1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        rep_cnt_d = '0;
        dly_cnt_d = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rep_cnt_q <= '0;
      dly_cnt_q <= '0;
      busy_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rep_cnt_q <= rep_cnt_d;
      dly_cnt_q <= dly_cnt_d;
      busy_q    <= busy_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
    end
  end

  assign busy = busy_q;
  assign pass = pass_q;
  assign fail = fail_q;

`ifdef IMPL_CHK_DROP_CNT_EN
  logic [CNTW-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if ((state_q != S_IDLE) && trigger && rm && (drop_cnt_q != {CNTW{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_impl_window_checker.sv
// Table-driven bench for impl_window_checker: each record holds one cycle of inputs and the outputs expected after that edge.
module tb_impl_window_checker;

  localparam int AW   = 5;
  localparam int RW   = 9;
  localparam int CNTW = 8;
  localparam int LW   = RW - AW;
`ifdef IMPL_CHK_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            write_en = 1'b0;
  logic            data_valid = 1'b0;
  logic [AW-1:0]   addr = 5'h0A;
  logic [RW-1:0]   retire_address = '0;
  logic [RW-1:0]   write_address = '0;
  logic            busy, pass, fail;
  logic [CNTW-1:0] drop_cnt;

  always #5 clk = ~clk;

  impl_window_checker #(
    .AW(AW), .RW(RW), .REPEAT(2), .MIN_DLY(3), .MAX_DLY(8), .CNTW(CNTW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .write_en       (write_en),
    .data_valid     (data_valid),
    .addr           (addr),
    .retire_address (retire_address),
    .write_address  (write_address),
    .busy           (busy),
    .pass           (pass),
    .fail           (fail),
    .drop_cnt       (drop_cnt)
  );

  typedef struct {
    bit r, we, dv, rmf, wmf;
    bit eb, ep, ef;
    int ed;
  } vec_t;

  typedef struct {
    bit              eb, ep, ef;
    logic [CNTW-1:0] ed;
    int              idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic void v(bit r, bit we, bit dv, bit rmf, bit wmf, bit eb, bit ep, bit ef, int ed);
    vec_t x;
    x.r = r; x.we = we; x.dv = dv; x.rmf = rmf; x.wmf = wmf;
    x.eb = eb; x.ep = ep; x.ef = ef; x.ed = ed;
    vecs.push_back(x);
  endfunction

  function automatic void idle(int n, bit eb, int ed);
    for (int i = 0; i < n; i++) v(0, 0, 0, 0, 0, eb, 0, 0, ed);
  endfunction

  // Random low bits exercise that only the top AW bits are compared.
  function automatic logic [RW-1:0] bus(bit match);
    logic [LW-1:0] low;
    logic [AW-1:0] fld;
    low = LW'($urandom);
    fld = match ? addr : (addr ^ 5'h11);
    return {fld, low};
  endfunction

  initial begin
    // A: cm at k=4 -> pass
    v(0,1,1,1,0, 1,0,0,0);  v(0,1,0,1,0, 1,0,0,0);
    idle(3, 1, 0);
    v(0,1,0,0,1, 0,1,0,0);  idle(2, 0, 0);
    // B: no cm -> fail after k=8
    v(0,1,1,1,0, 1,0,0,0);  v(0,1,0,1,0, 1,0,0,0);
    idle(7, 1, 0);
    v(0,0,0,0,0, 0,0,1,0);  idle(1, 0, 0);
    // C: early cm (k=2), cm with data_valid, cm without write_en -> still fail
    v(0,1,1,1,0, 1,0,0,0);  v(0,1,0,1,0, 1,0,0,0);
    idle(1, 1, 0);
    v(0,1,0,0,1, 1,0,0,0);
    idle(1, 1, 0);
    v(0,1,1,0,1, 1,0,0,0);
    v(0,0,0,0,1, 1,0,0,0);
    idle(2, 1, 0);
    v(0,0,0,0,0, 0,0,1,0);  idle(1, 0, 0);
    // D: vacuous antecedents (write_en low, then retire field mismatch)
    v(0,1,1,1,0, 1,0,0,0);  v(0,0,0,1,0, 0,0,0,0);  idle(1, 0, 0);
    v(0,1,1,1,0, 1,0,0,0);  v(0,1,0,0,0, 0,0,0,0);  idle(1, 0, 0);
    // E: two triggers dropped while waiting; attempt still passes at k=4
    v(0,1,1,1,0, 1,0,0,0);  v(0,1,0,1,0, 1,0,0,0);
    v(0,1,1,1,0, 1,0,0,1);  v(0,1,1,1,0, 1,0,0,2);
    idle(1, 1, 2);
    v(0,1,0,0,1, 0,1,0,2);  idle(1, 0, 2);
    // G: cm at k=MAX_DLY passes
    v(0,1,1,1,0, 1,0,0,2);  v(0,1,0,1,0, 1,0,0,2);
    idle(7, 1, 2);
    v(0,1,0,0,1, 0,1,0,2);
    // H: trigger in the report cycle is accepted; cm at k=1 ignored, k=MIN_DLY passes
    v(0,1,1,1,0, 1,0,0,2);  v(0,1,0,1,0, 1,0,0,2);
    v(0,1,0,0,1, 1,0,0,2);
    idle(1, 1, 2);
    v(0,1,0,0,1, 0,1,0,2);  idle(1, 0, 2);
    // F: reset in WAIT with a would-be hit; fresh attempt afterwards
    v(0,1,1,1,0, 1,0,0,2);  v(0,1,0,1,0, 1,0,0,2);
    idle(2, 1, 2);
    v(1,1,0,0,1, 0,0,0,0);
    idle(1, 0, 0);
    v(0,1,1,1,0, 1,0,0,0);  v(0,1,0,1,0, 1,0,0,0);
    idle(2, 1, 0);
    v(0,1,0,0,1, 0,1,0,0);  idle(2, 0, 0);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", -1, 32'(busy), 32'd0);
    check("reset_pass", -1, 32'(pass), 32'd0);
    check("reset_fail", -1, 32'(fail), 32'd0);
    check("reset_drop", -1, 32'(drop_cnt), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      exp_t got;
      @(negedge clk);
      rst            = vecs[i].r;
      write_en       = vecs[i].we;
      data_valid     = vecs[i].dv;
      retire_address = bus(vecs[i].rmf);
      write_address  = bus(vecs[i].wmf);
      e.eb = vecs[i].eb; e.ep = vecs[i].ep; e.ef = vecs[i].ef;
      e.ed = DROP_EN ? CNTW'(vecs[i].ed) : '0;
      e.idx = i;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      check("busy", got.idx, 32'(busy), 32'(got.eb));
      check("pass", got.idx, 32'(pass), 32'(got.ep));
      check("fail", got.idx, 32'(fail), 32'(got.ef));
      check("drop_cnt", got.idx, 32'(drop_cnt), 32'(got.ed));
      check("pass_and_fail", got.idx, 32'(pass & fail), 32'd0);
      $display("vec %0d: rst=%0b we=%0b dv=%0b rm=%0b wm=%0b -> busy=%0b pass=%0b fail=%0b drop=%0d",
               got.idx, vecs[i].r, vecs[i].we, vecs[i].dv, vecs[i].rmf, vecs[i].wmf,
               busy, pass, fail, drop_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
